// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types and constants for the Nexys2 arith blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } sub_state_t;

    localparam int unsigned ARITH_WIDTH_DEFAULT = 4;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell shared by the ripple and serial arithmetic units.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, one bit per clock through one full adder (b inverted, carry seeded to 1).
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf_o.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    sub_state_t       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:1] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] diff_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic             sum;
    logic             cout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    full_adder u_full_adder (
        .a_i (a_sh_q[0]),
        .b_i (~b_sh_q[0]),
        .c_i (carry_q),
        .s_o (sum),
        .c_o (cout)
    );

    // The LSB of the shifted accumulator is never needed, so only the upper bits are stored.
    assign acc_d = {sum, acc_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        acc_q   <= '0;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    acc_q   <= acc_d[WIDTH-1:1];
                    carry_q <= cout;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        diff_q   <= acc_d;
                        borrow_q <= ~cout;
`ifdef SERIAL_SUB_OVF_EN
                        // carry_q here is the carry into the MSB stage.
                        ovf_q    <= carry_q ^ cout;
`endif
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_o    = ovf_q;
`endif

endmodule
